bcd_ascii_serializer: RTL and testbench



---
 rtl/bcd_ascii_serializer.sv | 84 ++++++++
 tb/tb_bcd_ascii_serializer.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_ascii_serializer.sv
// bcd_ascii_serializer: streams a packed BCD word as ASCII digit bytes, MSD first.
module bcd_ascii_serializer #(
  parameter int DIGITS      = 4,
  parameter int LZ_SUPPRESS = 0,
  parameter int TERM_EN     = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4*DIGITS-1:0]   bcd,
  input  logic                  bcd_valid,
  output logic                  bcd_ready,
  output logic [7:0]            ascii,
  output logic                  ascii_valid,
  input  logic                  ascii_ready,
  output logic                  last,
  output logic                  validity,
  output logic                  busy
);
  localparam int W = 4 * DIGITS;
  typedef enum logic [1:0] {IDLE, DIGIT, TERM} state_t;
  state_t         state_q, state_d;
  logic [W-1:0]   sh_q, sh_d;
  logic [2:0]     idx_q, idx_d;
  logic           nz_q, nz_d;
  logic           vld_q, vld_d;
  logic           word_ok;
  logic [3:0]     cur;
  logic           blank;
  logic [7:0]     enc;
  assign cur   = sh_q[W-1 -: 4];
  // nz_q remembers that a nonzero (or illegal) digit has already gone out
  assign blank = (LZ_SUPPRESS != 0) && (cur == 4'd0) && !nz_q && (idx_q != 3'd0);
  assign enc   = (cur > 4'd9) ? 8'h3F : blank ? 8'h20 : {4'h3, cur};
  always_comb begin
    word_ok = 1'b1;
    for (int i = 0; i < DIGITS; i++)
      if (bcd[4*i +: 4] > 4'd9) word_ok = 1'b0;
  end
  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    idx_d   = idx_q;
    nz_d    = nz_q;
    vld_d   = vld_q;
    case (state_q)
      IDLE: if (bcd_valid) begin
        state_d = DIGIT;
        sh_d    = bcd;
        idx_d   = 3'(DIGITS - 1);
        nz_d    = 1'b0;
        vld_d   = word_ok;
      end
      DIGIT: if (ascii_ready) begin
        sh_d  = sh_q << 4;
        idx_d = idx_q - 3'd1;
        nz_d  = nz_q | (cur != 4'd0);
        if (idx_q == 3'd0) state_d = (TERM_EN != 0) ? TERM : IDLE;
      end
      TERM: if (ascii_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sh_q    <= '0;
      idx_q   <= '0;
      nz_q    <= 1'b0;
      vld_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      idx_q   <= idx_d;
      nz_q    <= nz_d;
      vld_q   <= vld_d;
    end
  end
  assign bcd_ready   = rst_n && (state_q == IDLE);
  assign ascii_valid = (state_q != IDLE);
  assign busy        = (state_q != IDLE);
  assign ascii       = (state_q == DIGIT) ? enc : (state_q == TERM) ? 8'h0D : 8'h00;
  assign last        = (state_q == DIGIT) ? (idx_q == 3'd0) && (TERM_EN == 0) : (state_q == TERM);
  assign validity    = vld_q;
endmodule

// File: tb/tb_bcd_ascii_serializer.sv
// tb_bcd_ascii_serializer: three variants (plain, leading-zero blanking, CR terminator) share stimulus.
module tb_bcd_ascii_serializer;
  typedef logic [8:0] bq_t[$];
  typedef struct {
    logic [15:0] w;
    logic [31:0] e0;
    logic [31:0] e1;
    bit          v;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] bcd = '0;
  logic        bcd_valid = 1'b0;
  logic        ascii_ready = 1'b1;
  bit          rnd = 1'b0;
  logic        bcd_ready[3], ascii_valid[3], last[3], validity[3], busy[3];
  logic [7:0]  ascii[3];
  bq_t         cap[3];
  vec_t        tbl[8];
  int          checks = 0, passes = 0;

  always #5 clk = ~clk;

  bcd_ascii_serializer #(.DIGITS(4), .LZ_SUPPRESS(0), .TERM_EN(0)) u0 (
    .clk(clk), .rst_n(rst_n), .bcd(bcd), .bcd_valid(bcd_valid), .bcd_ready(bcd_ready[0]),
    .ascii(ascii[0]), .ascii_valid(ascii_valid[0]), .ascii_ready(ascii_ready),
    .last(last[0]), .validity(validity[0]), .busy(busy[0]));
  bcd_ascii_serializer #(.DIGITS(4), .LZ_SUPPRESS(1), .TERM_EN(0)) u1 (
    .clk(clk), .rst_n(rst_n), .bcd(bcd), .bcd_valid(bcd_valid), .bcd_ready(bcd_ready[1]),
    .ascii(ascii[1]), .ascii_valid(ascii_valid[1]), .ascii_ready(ascii_ready),
    .last(last[1]), .validity(validity[1]), .busy(busy[1]));
  bcd_ascii_serializer #(.DIGITS(4), .LZ_SUPPRESS(0), .TERM_EN(1)) u2 (
    .clk(clk), .rst_n(rst_n), .bcd(bcd), .bcd_valid(bcd_valid), .bcd_ready(bcd_ready[2]),
    .ascii(ascii[2]), .ascii_valid(ascii_valid[2]), .ascii_ready(ascii_ready),
    .last(last[2]), .validity(validity[2]), .busy(busy[2]));

  always @(posedge clk)
    if (rst_n)
      for (int k = 0; k < 3; k++)
        if (ascii_valid[k] && ascii_ready) cap[k].push_back({last[k], ascii[k]});

  task automatic chk(string nm, logic [31:0] a, logic [31:0] e);
    checks++;
    if (a === e) passes++;
    else $display("FAIL %s: got %0h expected %0h", nm, a, e);
  endtask

  task automatic step();
    @(negedge clk);
    if (rnd) ascii_ready = ($urandom_range(0, 3) != 0);
  endtask

  // Reference: each digit taken arithmetically; blank zeros above the highest nonzero digit.
  function automatic bq_t model(logic [15:0] w, bit lz, bit term);
    bq_t q;
    int top = -1;
    int d;
    logic [7:0] b;
    for (int i = 0; i < 4; i++) if (((w >> (4 * i)) & 16'hF) != 0) top = i;
    for (int i = 3; i >= 0; i--) begin
      d = int'((w >> (4 * i)) & 16'hF);
      if (d > 9) b = 8'h3F;
      else if (lz && d == 0 && i > top && i != 0) b = 8'h20;
      else b = 8'(48 + d);
      q.push_back({(i == 0) && !term, b});
    end
    if (term) q.push_back({1'b1, 8'h0D});
    return q;
  endfunction

  function automatic bit legal(logic [15:0] w);
    for (int i = 0; i < 4; i++) if (((w >> (4 * i)) & 16'hF) > 9) return 1'b0;
    return 1'b1;
  endfunction

  function automatic bq_t from_const(logic [31:0] e, bit term);
    bq_t q;
    for (int i = 0; i < 4; i++) q.push_back({(i == 3) && !term, e[31 - 8 * i -: 8]});
    if (term) q.push_back({1'b1, 8'h0D});
    return q;
  endfunction

  task automatic cmp(string nm, int k, bq_t e);
    chk($sformatf("%s_len_u%0d", nm, k), cap[k].size(), e.size());
    for (int i = 0; i < e.size() && i < cap[k].size(); i++)
      chk($sformatf("%s_u%0d_byte%0d", nm, k, i), cap[k][i], e[i]);
  endtask

  task automatic clear_caps();
    for (int k = 0; k < 3; k++) cap[k].delete();
  endtask

  task automatic send(logic [15:0] w);
    int n = 0;
    while (!(bcd_ready[0] && bcd_ready[1] && bcd_ready[2]) && n < 200) begin step(); n++; end
    if (n >= 200) chk("ready_timeout", 0, 1);
    bcd = w;
    bcd_valid = 1'b1;
    step();
    bcd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy[0] || busy[1] || busy[2]) && n < 300) begin step(); n++; end
    if (n >= 300) chk("idle_timeout", 0, 1);
  endtask

  task automatic run_word(logic [15:0] w, string nm);
    clear_caps();
    send(w);
    wait_idle();
    cmp(nm, 0, model(w, 1'b0, 1'b0));
    cmp(nm, 1, model(w, 1'b1, 1'b0));
    cmp(nm, 2, model(w, 1'b0, 1'b1));
    for (int k = 0; k < 3; k++) chk($sformatf("%s_validity_u%0d", nm, k), validity[k], legal(w));
  endtask

  initial begin
    logic [15:0] w, m;
    int n;
    tbl[0] = '{16'h1234, 32'h31323334, 32'h31323334, 1'b1};
    tbl[1] = '{16'h0070, 32'h30303730, 32'h20203730, 1'b1};
    tbl[2] = '{16'h0000, 32'h30303030, 32'h20202030, 1'b1};
    tbl[3] = '{16'h0A05, 32'h303F3035, 32'h203F3035, 1'b0};
    tbl[4] = '{16'h12A4, 32'h31323F34, 32'h31323F34, 1'b0};
    tbl[5] = '{16'h5678, 32'h35363738, 32'h35363738, 1'b1};
    tbl[6] = '{16'h0009, 32'h30303039, 32'h20202039, 1'b1};
    tbl[7] = '{16'hF000, 32'h3F303030, 32'h3F303030, 1'b0};

    repeat (2) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rst_ascii_u%0d", k), ascii[k], 8'h00);
      chk($sformatf("rst_valid_u%0d", k), ascii_valid[k], 1'b0);
      chk($sformatf("rst_last_u%0d", k), last[k], 1'b0);
      chk($sformatf("rst_validity_u%0d", k), validity[k], 1'b1);
      chk($sformatf("rst_busy_u%0d", k), busy[k], 1'b0);
      chk($sformatf("rst_bcd_ready_u%0d", k), bcd_ready[k], 1'b0);
    end
    rst_n = 1'b1;
    #1 chk("bcd_ready_after_release", bcd_ready[0], 1'b1);

    // First byte one cycle after acceptance, then one byte per cycle.
    bcd = 16'h1234;
    bcd_valid = 1'b1;
    step();
    bcd_valid = 1'b0;
    chk("lat_valid", ascii_valid[0], 1'b1);
    chk("lat_ascii", ascii[0], 8'h31);
    chk("lat_bcd_ready", bcd_ready[0], 1'b0);
    chk("lat_busy", busy[0], 1'b1);
    for (int i = 1; i < 4; i++) begin
      step();
      chk($sformatf("seq_ascii%0d", i), ascii[0], 8'(8'h31 + i));
      chk($sformatf("seq_last%0d", i), last[0], i == 3);
    end
    step();
    chk("seq_ready_back", bcd_ready[0], 1'b1);
    chk("seq_valid_drop", ascii_valid[0], 1'b0);
    wait_idle();

    // Backpressure while 0x32 is presented.
    clear_caps();
    send(16'h1234);
    step();
    chk("stall_first", ascii[0], 8'h32);
    ascii_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("stall_hold_ascii%0d", i), ascii[0], 8'h32);
      chk($sformatf("stall_hold_valid%0d", i), ascii_valid[0], 1'b1);
      chk($sformatf("stall_hold_last%0d", i), last[0], 1'b0);
    end
    ascii_ready = 1'b1;
    wait_idle();
    cmp("stall", 0, from_const(32'h31323334, 1'b0));

    for (int t = 0; t < 8; t++) begin
      clear_caps();
      send(tbl[t].w);
      wait_idle();
      cmp($sformatf("tbl%0d", t), 0, from_const(tbl[t].e0, 1'b0));
      cmp($sformatf("tbl%0d", t), 1, from_const(tbl[t].e1, 1'b0));
      cmp($sformatf("tbl%0d", t), 2, from_const(tbl[t].e0, 1'b1));
      for (int k = 0; k < 3; k++) chk($sformatf("tbl%0d_validity_u%0d", t, k), validity[k], tbl[t].v);
    end

    // bcd_valid held high: the terminated variant must not accept again until after CR.
    clear_caps();
    bcd = 16'h9876;
    bcd_valid = 1'b1;
    step();
    n = 0;
    while (!bcd_ready[2] && n < 50) begin step(); n++; end
    bcd_valid = 1'b0;
    chk("term_period", n, 5);
    cmp("term_hold", 2, from_const(32'h39383736, 1'b1));
    wait_idle();

    // Asynchronous reset mid-word, after 0x32 has transferred.
    clear_caps();
    send(16'h12A4);
    wait_idle();
    clear_caps();
    send(16'h1234);
    step();
    step();
    chk("pre_reset_ascii", ascii[0], 8'h33);
    rst_n = 1'b0;
    #1;
    chk("areset_valid", ascii_valid[0], 1'b0);
    chk("areset_ascii", ascii[0], 8'h00);
    chk("areset_validity", validity[0], 1'b1);
    chk("areset_count", cap[0].size(), 2);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    for (int k = 0; k < 3; k++) chk($sformatf("post_reset_ready_u%0d", k), bcd_ready[k], 1'b1);
    run_word(16'h4321, "post_reset");

    rnd = 1'b1;
    for (int r = 0; r < 40; r++) begin
      w = 16'($urandom);
      m = 16'hFFFF >> (4 * $urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) w = w & m;
      run_word(w, $sformatf("rnd%0d", r));
    end
    rnd = 1'b0;
    ascii_ready = 1'b1;

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
